board_input_conditioner: RTL and testbench

//   Parametrised front end for the board's raw inputs: the buttons, the slide switches, and the rotary encoder (A/B/centre).

---
 rtl/board_input_conditioner.sv | 155 +++++++++++++++
 tb/tb_board_input_conditioner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_input_conditioner.sv
// Board input front end: two-flop sync and per-channel debounce for buttons, switches and
// the encoder push, plus quadrature decode of the rotary encoder into step/direction/position.
module board_input_conditioner #(
    parameter int unsigned N_BTN   = 4,
    parameter int unsigned N_SW    = 4,
    parameter int unsigned DEB_CYC = 500000,
    parameter int unsigned ROT_DEB = 5000,
    parameter int unsigned CNT_W   = 20,
    parameter int unsigned POS_W   = 8
) (
    input  logic             CCLK,
    input  logic             RSTN,
    input  logic [N_BTN-1:0] BTN_RAW,
    input  logic [N_SW-1:0]  SW_RAW,
    input  logic             ROTA,
    input  logic             ROTB,
    input  logic             ROTCTR,
    output logic [N_BTN-1:0] BTN_LVL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_REL,
    output logic [N_SW-1:0]  SW_LVL,
    output logic             ROTCTR_PRESS,
    output logic             ROT_STEP,
    output logic             ROT_DIR,
    output logic [POS_W-1:0] ROT_POS
);

    // Slow group: buttons, switches, encoder push (MSB). Fast group: {ROTB, ROTA}.
    localparam int unsigned N_D = N_BTN + N_SW + 1;
    localparam int unsigned N_R = 2;
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(ROT_DEB - 1);

    logic [N_D-1:0]   w_d_raw;
    logic [N_D-1:0]   r_d_s1;
    logic [N_D-1:0]   r_d_s2;
    logic [N_D-1:0]   r_d_stb;
    logic [N_D-1:0]   w_d_stb_nxt;
    logic [CNT_W-1:0] r_d_cnt     [N_D];
    logic [CNT_W-1:0] w_d_cnt_nxt [N_D];

    logic [N_R-1:0]   w_r_raw;
    logic [N_R-1:0]   r_r_s1;
    logic [N_R-1:0]   r_r_s2;
    logic [N_R-1:0]   r_r_stb;
    logic [N_R-1:0]   w_r_stb_nxt;
    logic [CNT_W-1:0] r_r_cnt     [N_R];
    logic [CNT_W-1:0] w_r_cnt_nxt [N_R];

    logic [N_BTN-1:0] w_btn_press;
    logic [N_BTN-1:0] w_btn_rel;
    logic             w_ctr_press;
    logic             w_a_rise;
    logic             w_b_new;

    logic [N_BTN-1:0] r_btn_press;
    logic [N_BTN-1:0] r_btn_rel;
    logic             r_ctr_press;
    logic             r_step;
    logic             r_dir;
    logic [POS_W-1:0] r_pos;

    assign w_d_raw = {ROTCTR, SW_RAW, BTN_RAW};
    assign w_r_raw = {ROTB, ROTA};

    // Slow-group debounce: accept a differing sample once it has persisted DEB_CYC edges.
    always_comb begin
        w_d_stb_nxt = r_d_stb;
        for (int unsigned i = 0; i < N_D; i++) begin
            w_d_cnt_nxt[i] = '0;
            if (r_d_s2[i] != r_d_stb[i]) begin
                if (r_d_cnt[i] == D_LAST) begin
                    w_d_stb_nxt[i] = r_d_s2[i];
                end else begin
                    w_d_cnt_nxt[i] = r_d_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Encoder-pin debounce, same rule with the shorter ROT_DEB window.
    always_comb begin
        w_r_stb_nxt = r_r_stb;
        for (int unsigned i = 0; i < N_R; i++) begin
            w_r_cnt_nxt[i] = '0;
            if (r_r_s2[i] != r_r_stb[i]) begin
                if (r_r_cnt[i] == R_LAST) begin
                    w_r_stb_nxt[i] = r_r_s2[i];
                end else begin
                    w_r_cnt_nxt[i] = r_r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_btn_press = w_d_stb_nxt[N_BTN-1:0] & ~r_d_stb[N_BTN-1:0];
    assign w_btn_rel   = ~w_d_stb_nxt[N_BTN-1:0] & r_d_stb[N_BTN-1:0];
    assign w_ctr_press = w_d_stb_nxt[N_D-1] & ~r_d_stb[N_D-1];
    // B is taken from its next accepted value so a same-edge B acceptance is honoured.
    assign w_a_rise    = w_r_stb_nxt[0] & ~r_r_stb[0];
    assign w_b_new     = w_r_stb_nxt[1];

    always_ff @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_d_s1  <= '0;
            r_d_s2  <= '0;
            r_d_stb <= '0;
            r_r_s1  <= '0;
            r_r_s2  <= '0;
            r_r_stb <= '0;
            for (int unsigned i = 0; i < N_D; i++) r_d_cnt[i] <= '0;
            for (int unsigned i = 0; i < N_R; i++) r_r_cnt[i] <= '0;
        end else begin
            r_d_s1  <= w_d_raw;
            r_d_s2  <= r_d_s1;
            r_d_stb <= w_d_stb_nxt;
            r_r_s1  <= w_r_raw;
            r_r_s2  <= r_r_s1;
            r_r_stb <= w_r_stb_nxt;
            for (int unsigned i = 0; i < N_D; i++) r_d_cnt[i] <= w_d_cnt_nxt[i];
            for (int unsigned i = 0; i < N_R; i++) r_r_cnt[i] <= w_r_cnt_nxt[i];
        end
    end

    // Event pulses and encoder position, registered alongside the level change.
    always_ff @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_btn_press <= '0;
            r_btn_rel   <= '0;
            r_ctr_press <= 1'b0;
            r_step      <= 1'b0;
            r_dir       <= 1'b0;
            r_pos       <= '0;
        end else begin
            r_btn_press <= w_btn_press;
            r_btn_rel   <= w_btn_rel;
            r_ctr_press <= w_ctr_press;
            r_step      <= w_a_rise;
            if (w_a_rise) begin
                r_dir <= ~w_b_new;
                r_pos <= w_b_new ? (r_pos - POS_W'(1)) : (r_pos + POS_W'(1));
            end
        end
    end

    assign BTN_LVL      = r_d_stb[N_BTN-1:0];
    assign SW_LVL       = r_d_stb[N_BTN +: N_SW];
    assign BTN_PRESS    = r_btn_press;
    assign BTN_REL      = r_btn_rel;
    assign ROTCTR_PRESS = r_ctr_press;
    assign ROT_STEP     = r_step;
    assign ROT_DIR      = r_dir;
    assign ROT_POS      = r_pos;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Bench for board_input_conditioner: directed scenarios plus random pin activity, checked each
// cycle against a sample-window reference model of synchronise/debounce/decode.
module tb_board_input_conditioner;

    localparam int NB   = 4;
    localparam int NS   = 4;
    localparam int ND   = NB + NS + 1;
    localparam int DEB  = 4;
    localparam int RDEB = 3;

    logic          clk;
    logic          rstn;
    logic [NB-1:0] btn;
    logic [NS-1:0] sw;
    logic          rota, rotb, rotctr;

    logic [NB-1:0] BTN_LVL, BTN_PRESS, BTN_REL;
    logic [NS-1:0] SW_LVL;
    logic          ROTCTR_PRESS, ROT_STEP, ROT_DIR;
    logic [7:0]    ROT_POS;

    board_input_conditioner #(
        .N_BTN(NB), .N_SW(NS), .DEB_CYC(DEB), .ROT_DEB(RDEB), .CNT_W(4), .POS_W(8)
    ) dut (
        .CCLK(clk), .RSTN(rstn), .BTN_RAW(btn), .SW_RAW(sw),
        .ROTA(rota), .ROTB(rotb), .ROTCTR(rotctr),
        .BTN_LVL(BTN_LVL), .BTN_PRESS(BTN_PRESS), .BTN_REL(BTN_REL), .SW_LVL(SW_LVL),
        .ROTCTR_PRESS(ROTCTR_PRESS), .ROT_STEP(ROT_STEP), .ROT_DIR(ROT_DIR), .ROT_POS(ROT_POS)
    );

    always #5 clk = ~clk;

    int n_asserts;
    int n_fail;

    // Reference model: per-edge pin history; a channel flips once the samples that reached
    // the sync output over the last window all disagree with its accepted level.
    logic [ND-1:0] qd[$];
    logic [1:0]    qr[$];
    logic [ND-1:0] m_stb;
    logic [1:0]    m_rstb;
    logic [NB-1:0] m_press, m_rel;
    logic          m_ctr_press, m_step, m_dir;
    logic [7:0]    m_pos;

    task automatic model_reset();
        qd.delete();
        qr.delete();
        for (int k = 0; k < 2 + DEB; k++) qd.push_back('0);
        for (int k = 0; k < 2 + RDEB; k++) qr.push_back('0);
        m_stb = '0; m_rstb = '0; m_press = '0; m_rel = '0;
        m_ctr_press = 1'b0; m_step = 1'b0; m_dir = 1'b0; m_pos = '0;
    endtask

    task automatic model_edge();
        logic [ND-1:0] nd;
        logic [1:0]    nr;
        bit            diff;
        if (!rstn) begin
            model_reset();
            return;
        end
        qd.push_front({rotctr, sw, btn});
        void'(qd.pop_back());
        qr.push_front({rotb, rota});
        void'(qr.pop_back());
        nd = m_stb;
        for (int i = 0; i < ND; i++) begin
            diff = 1'b1;
            for (int k = 2; k < 2 + DEB; k++) if (qd[k][i] == m_stb[i]) diff = 1'b0;
            if (diff) nd[i] = ~m_stb[i];
        end
        nr = m_rstb;
        for (int i = 0; i < 2; i++) begin
            diff = 1'b1;
            for (int k = 2; k < 2 + RDEB; k++) if (qr[k][i] == m_rstb[i]) diff = 1'b0;
            if (diff) nr[i] = ~m_rstb[i];
        end
        m_press     = nd[NB-1:0] & ~m_stb[NB-1:0];
        m_rel       = ~nd[NB-1:0] & m_stb[NB-1:0];
        m_ctr_press = nd[ND-1] & ~m_stb[ND-1];
        m_step      = nr[0] & ~m_rstb[0];
        if (m_step) begin
            m_dir = ~nr[1];
            m_pos = nr[1] ? m_pos - 8'd1 : m_pos + 8'd1;
        end
        m_stb  = nd;
        m_rstb = nr;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("btn_lvl",   32'(BTN_LVL),      32'(m_stb[NB-1:0]));
        chk("btn_press", 32'(BTN_PRESS),    32'(m_press));
        chk("btn_rel",   32'(BTN_REL),      32'(m_rel));
        chk("sw_lvl",    32'(SW_LVL),       32'(m_stb[NB +: NS]));
        chk("ctr_press", 32'(ROTCTR_PRESS), 32'(m_ctr_press));
        chk("rot_step",  32'(ROT_STEP),     32'(m_step));
        chk("rot_dir",   32'(ROT_DIR),      32'(m_dir));
        chk("rot_pos",   32'(ROT_POS),      32'(m_pos));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({BTN_LVL, BTN_PRESS, BTN_REL, SW_LVL, ROTCTR_PRESS, ROT_STEP, ROT_DIR, ROT_POS}), 32'd0);
    endtask

    initial begin
        logic seen;
        n_asserts = 0;
        n_fail    = 0;
        clk = 1'b0; rstn = 1'b0; btn = 4'hF; sw = '0; rota = 1'b0; rotb = 1'b0; rotctr = 1'b0;
        model_reset();
        #1;
        chk_all_zero("rst_hold_t0");
        ticks(3);
        chk_all_zero("rst_hold_t3");

        // Buttons held through reset register as a fresh press 6 edges after release.
        rstn = 1'b1;
        ticks(5);
        chk("t1_lvl_c5", 32'(BTN_LVL), 32'h0);
        tick();
        chk("t1_lvl_c6", 32'(BTN_LVL), 32'hF);
        chk("t1_press_c6", 32'(BTN_PRESS), 32'hF);
        tick();
        chk("t1_press_c7", 32'(BTN_PRESS), 32'h0);
        btn = 4'h0;
        ticks(8);
        chk("t1_released", 32'(BTN_LVL), 32'h0);

        // Short glitch rejected, then a held press accepted.
        btn[0] = 1'b1;
        ticks(3);
        btn[0] = 1'b0;
        ticks(8);
        chk("t2_glitch_lvl", 32'(BTN_LVL[0]), 32'h0);
        btn[0] = 1'b1;
        ticks(5);
        chk("t2_lvl_c5", 32'(BTN_LVL[0]), 32'h0);
        tick();
        chk("t2_lvl_c6", 32'(BTN_LVL[0]), 32'h1);
        chk("t2_press_c6", 32'(BTN_PRESS), 32'h1);

        // Release of button 0 together with a switch pattern.
        ticks(2);
        btn[0] = 1'b0;
        sw = 4'hA;
        ticks(5);
        chk("t3_rel_c5", 32'(BTN_REL), 32'h0);
        chk("t3_sw_c5", 32'(SW_LVL), 32'h0);
        tick();
        chk("t3_rel_c6", 32'(BTN_REL), 32'h1);
        chk("t3_lvl_c6", 32'(BTN_LVL[0]), 32'h0);
        chk("t3_sw_c6", 32'(SW_LVL), 32'hA);
        tick();
        chk("t3_rel_c7", 32'(BTN_REL), 32'h0);

        // CCW from 0 wraps to 255, A fall gives nothing, then CW from 255 wraps to 0.
        rotb = 1'b1;
        ticks(8);
        chk("t5_b_no_step", 32'(ROT_STEP), 32'h0);
        rota = 1'b1;
        ticks(4);
        chk("t5_step_c4", 32'(ROT_STEP), 32'h0);
        tick();
        chk("t5_step_c5", 32'(ROT_STEP), 32'h1);
        chk("t5_dir", 32'(ROT_DIR), 32'h0);
        chk("t5_pos", 32'(ROT_POS), 32'hFF);
        tick();
        chk("t5_step_c6", 32'(ROT_STEP), 32'h0);
        rota = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            seen = seen | ROT_STEP;
        end
        chk("t5_fall_no_step", 32'(seen), 32'h0);
        rotb = 1'b0;
        ticks(8);
        rota = 1'b1;
        ticks(4);
        chk("t4_step_c4", 32'(ROT_STEP), 32'h0);
        tick();
        chk("t4_step_c5", 32'(ROT_STEP), 32'h1);
        chk("t4_dir", 32'(ROT_DIR), 32'h1);
        chk("t4_pos", 32'(ROT_POS), 32'h00);
        ticks(4);

        // Reset mid-debounce discards the partial count.
        btn[1] = 1'b1;
        ticks(2);
        rstn = 1'b0;
        btn[1] = 1'b0;
        #1;
        chk_all_zero("t6_async_rst");
        ticks(2);
        chk_all_zero("t6_rst_hold");
        rstn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            seen = seen | BTN_PRESS[1];
        end
        chk("t6_no_press", 32'(seen), 32'h0);
        chk("t6_lvl", 32'(BTN_LVL[1]), 32'h0);

        // Random pin activity with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            rstn = ($urandom_range(399) != 0);
            for (int i = 0; i < NB; i++) if ($urandom_range(7) == 0) btn[i] = ~btn[i];
            for (int i = 0; i < NS; i++) if ($urandom_range(7) == 0) sw[i] = ~sw[i];
            if ($urandom_range(7) == 0) rotctr = ~rotctr;
            if ($urandom_range(5) == 0) rota = ~rota;
            if ($urandom_range(5) == 0) rotb = ~rotb;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
